// File: rtl/game_flow_controller_if.sv
// ---------------------------------------------------------------------------
// game_flow_controller_if
// Groups the match-control signals exchanged between the Pong top level and
// the game flow controller.
//   master : the top level side (drives start, tick and goal pulses; observes
//            enables, serve request, scores, winner and debug state)
//   slave  : the controller side (the opposite directions)
// Signals:
//   start      raw start button level, asynchronous to clk
//   tick       one-cycle game tick strobe, synchronous to clk
//   goal_p1    one-cycle pulse, point to P1
//   goal_p2    one-cycle pulse, point to P2
//   ball_en    ball engine may move
//   paddle_en  paddle engine may move
//   timer_en   match timer may count
//   serve_req  one-cycle pulse, recentre and launch the ball
//   serve_dir  0 = toward P1 (left), 1 = toward P2 (right)
//   score1     P1 score
//   score2     P2 score
//   winner     00 none, 01 P1, 10 P2
//   state      current state encoding (debug)
// ---------------------------------------------------------------------------
interface game_flow_controller_if;
  logic       start;
  logic       tick;
  logic       goal_p1;
  logic       goal_p2;
  logic       ball_en;
  logic       paddle_en;
  logic       timer_en;
  logic       serve_req;
  logic       serve_dir;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] winner;
  logic [2:0] state;

  modport master (
    output start, tick, goal_p1, goal_p2,
    input  ball_en, paddle_en, timer_en, serve_req, serve_dir,
    input  score1, score2, winner, state
  );

  modport slave (
    input  start, tick, goal_p1, goal_p2,
    output ball_en, paddle_en, timer_en, serve_req, serve_dir,
    output score1, score2, winner, state
  );
endinterface

// File: rtl/game_flow_controller.sv
// ---------------------------------------------------------------------------
// game_flow_controller
// Match sequencer for the Pong top level. Owns match state, scores and serve
// direction, gates the ball/paddle/timer engines through enables, consumes
// goal pulses and paces SERVE and POINT phases from the game tick strobe.
//
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-low
//   bus  game_flow_controller_if.slave (start, tick, goal_p1, goal_p2 in;
//        ball_en, paddle_en, timer_en, serve_req, serve_dir, score1, score2,
//        winner, state out)
//
// Parameters:
//   WIN_SCORE    points needed to win (1..15)
//   SERVE_TICKS  ticks spent in SERVE before launch (>=1)
//   POINT_TICKS  ticks spent in POINT after a goal (>=1)
//
// Configuration macro:
//   PAUSE_FEATURE_EN  when defined, a start press in PLAY pauses the match
//                     and a further press resumes it without a new serve.
// ---------------------------------------------------------------------------
module game_flow_controller #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 60,
  parameter int POINT_TICKS = 90
) (
  input logic                  clk,
  input logic                  rst,
  game_flow_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4,
    ST_PAUSE = 3'd5
  } state_t;

  // The tick counter only ever holds values up to max(SERVE,POINT)-1; the +1
  // keeps the width non-zero when both phase lengths are 1.
  localparam int MAX_TICKS = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS) + 1;

  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_TICKS - 1);
  localparam logic [3:0]       WIN_VAL    = 4'(WIN_SCORE);

  state_t           state_r;
  logic [CNT_W-1:0] tick_cnt_r;
  logic [3:0]       score1_r;
  logic [3:0]       score2_r;
  logic [1:0]       winner_r;
  logic             serve_dir_r;
  logic             serve_req_r;

  logic             start_meta_r;
  logic             start_sync_r;
  logic             start_prev_r;

  logic             start_p_s;
  logic [3:0]       score1_inc_s;
  logic [3:0]       score2_inc_s;
  logic [2:0]       en_s;   // {ball, paddle, timer}

  // Two-flop synchronizer for the raw button plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_meta_r <= 1'b0;
      start_sync_r <= 1'b0;
      start_prev_r <= 1'b0;
    end else begin
      start_meta_r <= bus.start;
      start_sync_r <= start_meta_r;
      start_prev_r <= start_sync_r;
    end
  end

  assign start_p_s    = start_sync_r & ~start_prev_r;
  assign score1_inc_s = score1_r + 4'd1;
  assign score2_inc_s = score2_r + 4'd1;

  // Match state machine: state, tick pacing, scoring and serve control.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      tick_cnt_r  <= '0;
      score1_r    <= 4'd0;
      score2_r    <= 4'd0;
      winner_r    <= 2'b00;
      serve_dir_r <= 1'b1;
      serve_req_r <= 1'b0;
    end else begin
      serve_req_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_p_s) begin
            state_r    <= ST_SERVE;
            score1_r   <= 4'd0;
            score2_r   <= 4'd0;
            winner_r   <= 2'b00;
            tick_cnt_r <= '0;
          end
        end

        ST_SERVE: begin
          if (bus.tick) begin
            if (tick_cnt_r == SERVE_LAST) begin
              state_r     <= ST_PLAY;
              serve_req_r <= 1'b1;
              tick_cnt_r  <= '0;
            end else begin
              tick_cnt_r <= tick_cnt_r + CNT_W'(1);
            end
          end
        end

        ST_PLAY: begin
          // Simultaneous goals are contradictory and are discarded.
          if (bus.goal_p1 && !bus.goal_p2) begin
            score1_r    <= score1_inc_s;
            serve_dir_r <= 1'b1;
            tick_cnt_r  <= '0;
            if (score1_inc_s == WIN_VAL) begin
              state_r  <= ST_OVER;
              winner_r <= 2'b01;
            end else begin
              state_r <= ST_POINT;
            end
          end else if (bus.goal_p2 && !bus.goal_p1) begin
            score2_r    <= score2_inc_s;
            serve_dir_r <= 1'b0;
            tick_cnt_r  <= '0;
            if (score2_inc_s == WIN_VAL) begin
              state_r  <= ST_OVER;
              winner_r <= 2'b10;
            end else begin
              state_r <= ST_POINT;
            end
`ifdef PAUSE_FEATURE_EN
          end else if (start_p_s) begin
            state_r <= ST_PAUSE;
`endif
          end
        end

        ST_POINT: begin
          if (bus.tick) begin
            if (tick_cnt_r == POINT_LAST) begin
              state_r    <= ST_SERVE;
              tick_cnt_r <= '0;
            end else begin
              tick_cnt_r <= tick_cnt_r + CNT_W'(1);
            end
          end
        end

        ST_OVER: begin
          // Scores and winner stay visible in IDLE until the next match starts.
          if (start_p_s) begin
            state_r <= ST_IDLE;
          end
        end

`ifdef PAUSE_FEATURE_EN
        ST_PAUSE: begin
          // Resume in place: no serve request, counters and scores untouched.
          if (start_p_s) begin
            state_r <= ST_PLAY;
          end
        end
`endif

        default: begin
          // Unreachable encodings recover to a safe idle match.
          state_r    <= ST_IDLE;
          tick_cnt_r <= '0;
        end
      endcase
    end
  end

  // Engine enables decoded straight from the registered state.
  always_comb begin
    en_s = 3'b000;
    case (state_r)
      ST_IDLE:  en_s = 3'b000;
      ST_SERVE: en_s = 3'b011;
      ST_PLAY:  en_s = 3'b111;
      ST_POINT: en_s = 3'b010;
      ST_OVER:  en_s = 3'b000;
      default:  en_s = 3'b000;
    endcase
  end

  assign bus.ball_en   = en_s[2];
  assign bus.paddle_en = en_s[1];
  assign bus.timer_en  = en_s[0];
  assign bus.serve_req = serve_req_r;
  assign bus.serve_dir = serve_dir_r;
  assign bus.score1    = score1_r;
  assign bus.score2    = score2_r;
  assign bus.winner    = winner_r;
  assign bus.state     = state_r;

endmodule

// File: tb/tb_game_flow_controller.sv
// ---------------------------------------------------------------------------
// tb_game_flow_controller
// Directed bench for game_flow_controller with WIN_SCORE=3, SERVE_TICKS=4,
// POINT_TICKS=3. A table of per-cycle inputs and expected outputs walks a
// whole match; hand-written sequences cover async reset mid-play and the
// start-in-PLAY behaviour (pause when PAUSE_FEATURE_EN is defined).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_game_flow_controller;

  logic clk;
  logic rst;

  game_flow_controller_if bus ();

  game_flow_controller #(
    .WIN_SCORE  (3),
    .SERVE_TICKS(4),
    .POINT_TICKS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        tick;
    logic        g1;
    logic        g2;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  // Enables per state: {ball, paddle, timer}.
  function automatic logic [2:0] exp_en(input logic [2:0] st);
    case (st)
      3'd1:    return 3'b011;
      3'd2:    return 3'b111;
      3'd3:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [17:0] pack_exp(input logic [2:0] st, input logic req,
                                           input logic dir, input logic [3:0] s1,
                                           input logic [3:0] s2, input logic [1:0] w);
    return {st, exp_en(st), req, dir, s1, s2, w};
  endfunction

  function automatic logic [17:0] actual();
    return {bus.state, bus.ball_en, bus.paddle_en, bus.timer_en, bus.serve_req,
            bus.serve_dir, bus.score1, bus.score2, bus.winner};
  endfunction

  task automatic add(input logic s, input logic t, input logic g1, input logic g2,
                     input logic [2:0] st, input logic req, input logic dir,
                     input logic [3:0] s1, input logic [3:0] s2, input logic [1:0] w);
    vec_t v;
    v.start = s; v.tick = t; v.g1 = g1; v.g2 = g2;
    v.exp   = pack_exp(st, req, dir, s1, s2, w);
    vecs.push_back(v);
  endtask

  task automatic compare(input string name, input logic [17:0] exp);
    logic [17:0] act;
    act = actual();
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got st=%0d en=%b req=%b dir=%b s1=%0d s2=%0d w=%b, want st=%0d en=%b req=%b dir=%b s1=%0d s2=%0d w=%b",
               name, act[17:15], act[14:12], act[11], act[10], act[9:6], act[5:2], act[1:0],
               exp[17:15], exp[14:12], exp[11], exp[10], exp[9:6], exp[5:2], exp[1:0]);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic s, input logic t, input logic g1, input logic g2);
    @(negedge clk);
    bus.start = s; bus.tick = t; bus.goal_p1 = g1; bus.goal_p2 = g2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0; bus.tick = 1'b0; bus.goal_p1 = 1'b0; bus.goal_p2 = 1'b0;

    // Full match to 3 for P1, then OVER -> IDLE -> new match.
    add(1,0,0,0, 3'd0,0,1,4'd0,4'd0,2'b00);
    add(1,0,0,0, 3'd0,0,1,4'd0,4'd0,2'b00);
    add(1,0,0,0, 3'd1,0,1,4'd0,4'd0,2'b00);  // 3 clk after start edge
    add(0,1,0,0, 3'd1,0,1,4'd0,4'd0,2'b00);
    add(0,0,0,0, 3'd1,0,1,4'd0,4'd0,2'b00);
    add(0,1,0,0, 3'd1,0,1,4'd0,4'd0,2'b00);
    add(0,1,0,0, 3'd1,0,1,4'd0,4'd0,2'b00);
    add(0,1,0,0, 3'd2,1,1,4'd0,4'd0,2'b00);  // 4th tick: launch
    add(0,1,0,0, 3'd2,0,1,4'd0,4'd0,2'b00);  // req one clk only; tick ignored
    add(0,0,0,1, 3'd3,0,0,4'd0,4'd1,2'b00);  // goal P2
    add(0,0,1,0, 3'd3,0,0,4'd0,4'd1,2'b00);  // goal outside PLAY ignored
    add(0,1,0,0, 3'd3,0,0,4'd0,4'd1,2'b00);
    add(0,1,0,0, 3'd3,0,0,4'd0,4'd1,2'b00);
    add(0,1,0,0, 3'd1,0,0,4'd0,4'd1,2'b00);  // POINT done
    for (int i = 0; i < 3; i++) add(0,1,0,0, 3'd1,0,0,4'd0,4'd1,2'b00);
    add(0,1,0,0, 3'd2,1,0,4'd0,4'd1,2'b00);
    add(0,0,1,1, 3'd2,0,0,4'd0,4'd1,2'b00);  // simultaneous goals ignored
    add(0,0,1,0, 3'd3,0,1,4'd1,4'd1,2'b00);
    for (int i = 0; i < 2; i++) add(0,1,0,0, 3'd3,0,1,4'd1,4'd1,2'b00);
    add(0,1,0,0, 3'd1,0,1,4'd1,4'd1,2'b00);
    for (int i = 0; i < 3; i++) add(0,1,0,0, 3'd1,0,1,4'd1,4'd1,2'b00);
    add(0,1,0,0, 3'd2,1,1,4'd1,4'd1,2'b00);
    add(0,0,1,0, 3'd3,0,1,4'd2,4'd1,2'b00);
    for (int i = 0; i < 2; i++) add(0,1,0,0, 3'd3,0,1,4'd2,4'd1,2'b00);
    add(0,1,0,0, 3'd1,0,1,4'd2,4'd1,2'b00);
    for (int i = 0; i < 3; i++) add(0,1,0,0, 3'd1,0,1,4'd2,4'd1,2'b00);
    add(0,1,0,0, 3'd2,1,1,4'd2,4'd1,2'b00);
    add(0,0,1,0, 3'd4,0,1,4'd3,4'd1,2'b01);  // P1 wins
    add(0,1,0,1, 3'd4,0,1,4'd3,4'd1,2'b01);  // OVER ignores tick/goal
    add(1,0,0,0, 3'd4,0,1,4'd3,4'd1,2'b01);
    add(1,0,0,0, 3'd4,0,1,4'd3,4'd1,2'b01);
    add(1,0,0,0, 3'd0,0,1,4'd3,4'd1,2'b01);  // IDLE keeps result visible
    add(1,0,0,0, 3'd0,0,1,4'd3,4'd1,2'b01);
    add(0,0,0,0, 3'd0,0,1,4'd3,4'd1,2'b01);
    add(0,0,0,0, 3'd0,0,1,4'd3,4'd1,2'b01);
    add(1,0,0,0, 3'd0,0,1,4'd3,4'd1,2'b01);
    add(1,0,0,0, 3'd0,0,1,4'd3,4'd1,2'b01);
    add(1,0,0,0, 3'd1,0,1,4'd0,4'd0,2'b00);  // new match clears

    repeat (2) @(posedge clk);
    #1;
    compare("reset_state", pack_exp(3'd0,1'b0,1'b1,4'd0,4'd0,2'b00));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].start, vecs[i].tick, vecs[i].g1, vecs[i].g2);
      compare($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Goal during SERVE is ignored, then play up to score1=2 and reset.
    step(0,0,0,1);
    compare("goal_in_serve", pack_exp(3'd1,1'b0,1'b1,4'd0,4'd0,2'b00));
    repeat (4) step(0,1,0,0);
    step(0,0,1,0);
    repeat (3) step(0,1,0,0);
    repeat (4) step(0,1,0,0);
    step(0,0,1,0);
    compare("second_point", pack_exp(3'd3,1'b0,1'b1,4'd2,4'd0,2'b00));
    repeat (3) step(0,1,0,0);
    repeat (4) step(0,1,0,0);
    compare("play_s1_2", pack_exp(3'd2,1'b1,1'b1,4'd2,4'd0,2'b00));
    #2;
    rst = 1'b0;
    #1;
    compare("reset_mid_play", pack_exp(3'd0,1'b0,1'b1,4'd0,4'd0,2'b00));
    step(1,1,1,0);
    compare("reset_held", pack_exp(3'd0,1'b0,1'b1,4'd0,4'd0,2'b00));
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;

    // Start a match, reach PLAY, then press start while playing.
    repeat (3) step(1,0,0,0);
    compare("restart_serve", pack_exp(3'd1,1'b0,1'b1,4'd0,4'd0,2'b00));
    repeat (4) step(0,1,0,0);
    compare("restart_play", pack_exp(3'd2,1'b1,1'b1,4'd0,4'd0,2'b00));
    repeat (3) step(1,0,0,0);
`ifdef PAUSE_FEATURE_EN
    compare("pause_enter", pack_exp(3'd5,1'b0,1'b1,4'd0,4'd0,2'b00));
    step(1,1,1,0);
    compare("pause_ignores", pack_exp(3'd5,1'b0,1'b1,4'd0,4'd0,2'b00));
    repeat (2) step(0,0,0,0);
    repeat (3) step(1,0,0,0);
    compare("pause_resume", pack_exp(3'd2,1'b0,1'b1,4'd0,4'd0,2'b00));
    step(1,0,0,0);
    compare("resume_no_req", pack_exp(3'd2,1'b0,1'b1,4'd0,4'd0,2'b00));
`else
    compare("start_in_play", pack_exp(3'd2,1'b0,1'b1,4'd0,4'd0,2'b00));
    step(1,0,0,1);
    compare("play_after_start", pack_exp(3'd3,1'b0,1'b0,4'd0,4'd1,2'b00));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
